sap1_controller_sequencer: RTL and testbench



---
 rtl/sap1_pkg.sv | 52 +++++
 rtl/sap1_controller_sequencer_if.sv | 15 +
 rtl/sap1_ring_counter.sv | 40 ++++
 rtl/sap1_controller_sequencer.sv | 83 ++++++++
 tb/tb_sap1_controller_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, control-word
// field positions, control-word values and one-hot T-state encodings.
package sap1_pkg;

    localparam int NUM_T_DEF = 6;
    localparam int CON_W_DEF = 12;

    // Opcodes (instruction register upper nibble)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control-word field positions, MSB first
    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    // Idle: every active-low strobe high, every active-high strobe low
    localparam logic [11:0] CON_IDLE = (12'd1 << CON_LM_N) | (12'd1 << CON_CE_N) |
                                       (12'd1 << CON_LI_N) | (12'd1 << CON_EI_N) |
                                       (12'd1 << CON_LA_N) | (12'd1 << CON_LB_N) |
                                       (12'd1 << CON_LO_N);
    localparam logic [11:0] CON_T1       = 12'h5E3;  // PC onto bus, load MAR
    localparam logic [11:0] CON_T2       = 12'hBE3;  // increment PC
    localparam logic [11:0] CON_T3       = 12'h263;  // RAM onto bus, load IR
    localparam logic [11:0] CON_MEM_ADDR = 12'h1A3;  // IR operand onto bus, load MAR
    localparam logic [11:0] CON_LDA_T5   = 12'h2C3;  // RAM into accumulator
    localparam logic [11:0] CON_B_LOAD   = 12'h2E1;  // RAM into B register
    localparam logic [11:0] CON_ADD_T6   = 12'h3C7;  // ALU sum into accumulator
    localparam logic [11:0] CON_SUB_T6   = 12'h3CF;  // ALU difference into accumulator
    localparam logic [11:0] CON_OUT_T4   = 12'h3F2;  // accumulator into output register

    // One-hot ring states
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Bus between the sequencer and the rest of the SAP-1 machine: step control
// and opcode in, control word, ring state and halt out.
interface sap1_controller_sequencer_if;
    import sap1_pkg::*;

    logic                 step_en;
    logic [3:0]           opcode;
    logic [CON_W_DEF-1:0] con;
    logic [NUM_T_DEF-1:0] t_state;
    logic                 hlt;

    modport master (output step_en, output opcode, input con, input t_state, input hlt);
    modport slave  (input step_en, input opcode, output con, output t_state, output hlt);

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring: rotates on advance_i, holds otherwise, and falls back
// to T1 from any non-one-hot value.
module sap1_ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance_i,
    output logic [NUM_T-1:0] t_state_o
);

    logic [NUM_T-1:0] ring_q;
    logic [NUM_T-1:0] ring_d;

    function automatic logic is_onehot(input logic [NUM_T-1:0] v);
        return (v != '0) && ((v & (v - NUM_T'(1))) == '0);
    endfunction

    // Next ring value: recover, rotate or hold
    always_comb begin
        ring_d = ring_q;
        if (!is_onehot(ring_q)) begin
            ring_d = NUM_T'(1);
        end else if (advance_i) begin
            ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
        end
    end

    // Ring state register, reset to T1
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_q <= NUM_T'(1);
        end else begin
            ring_q <= ring_d;
        end
    end

    assign t_state_o = ring_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control/sequencer: T-state ring plus combinational decode of the
// control word from (T-state, opcode, halt), and the machine halt flag.
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter int NUM_T = 6,
    parameter int CON_W = 12
) (
    input logic                        clk,
    input logic                        reset,
    sap1_controller_sequencer_if.slave bus
);

    logic [NUM_T-1:0] t_state;
    logic             halted_q;
    logic             halted_d;
    logic             halt_now;
    logic             hlt;
    logic [CON_W-1:0] con_dec;

    // The ring must not leave T4 on the very edge that sets the halt flag,
    // so advance is gated by the combinational halt, not only the register.
    sap1_ring_counter #(
        .NUM_T(NUM_T)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .advance_i(bus.step_en & ~hlt),
        .t_state_o(t_state)
    );

    assign halt_now = (t_state == T4) && (bus.opcode == OP_HLT);
    assign halted_d = halted_q | halt_now;
    assign hlt      = ~reset & halted_d;

    // Halt flag: set by HLT in T4, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Control-word decode; opcode only matters in T4..T6
    always_comb begin
        con_dec = CON_IDLE;
        if (!reset && !hlt) begin
            case (t_state)
                T1: con_dec = CON_T1;
                T2: con_dec = CON_T2;
                T3: con_dec = CON_T3;
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: con_dec = CON_MEM_ADDR;
                        OP_OUT:                 con_dec = CON_OUT_T4;
                        default:                con_dec = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA:         con_dec = CON_LDA_T5;
                        OP_ADD, OP_SUB: con_dec = CON_B_LOAD;
                        default:        con_dec = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (bus.opcode)
                        OP_ADD:  con_dec = CON_ADD_T6;
                        OP_SUB:  con_dec = CON_SUB_T6;
                        default: con_dec = CON_IDLE;
                    endcase
                end
                default: con_dec = CON_IDLE;
            endcase
        end
    end

    assign bus.con     = con_dec;
    assign bus.t_state = t_state;
    assign bus.hlt     = hlt;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench for the SAP-1 controller/sequencer: directed scenarios
// plus randomized cycles compared against a step-number/opcode table model.
module tb_sap1_controller_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Reference model: current T-step as a number 1..6 and the halted flag
    int   m_step = 1;
    bit   m_halted = 1'b0;

    always #5 clk = ~clk;

    sap1_controller_sequencer_if bus_if ();

    sap1_controller_sequencer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    function automatic logic [11:0] exp_con(input int step, input logic [3:0] op,
                                            input bit halted, input logic rst);
        if (rst || halted || (step == 4 && op == 4'hF)) return 12'h3E3;
        case (step)
            1: return 12'h5E3;
            2: return 12'hBE3;
            3: return 12'h263;
            4: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h1A3 :
                      (op == 4'hE) ? 12'h3F2 : 12'h3E3;
            5: return (op == 4'h0) ? 12'h2C3 :
                      (op == 4'h1 || op == 4'h2) ? 12'h2E1 : 12'h3E3;
            6: return (op == 4'h1) ? 12'h3C7 : (op == 4'h2) ? 12'h3CF : 12'h3E3;
            default: return 12'h3E3;
        endcase
    endfunction

    // One clock: advance the model with the inputs seen at the edge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_step   = 1;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 4 && bus_if.opcode == 4'hF) m_halted = 1'b1;
            else if (bus_if.step_en) m_step = (m_step == 6) ? 1 : m_step + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.step_en = 1'b1;
        bus_if.opcode  = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {6'h01, 12'h3E3, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got t=%h con=%h hlt=%b, want t=01 con=3E3 hlt=0",
                         i, bus_if.t_state, bus_if.con, bus_if.hlt);
            end
            checks++;
        end
        reset = 1'b0;
        #1;
        if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {6'h01, 12'h5E3, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got t=%h con=%h hlt=%b, want t=01 con=5E3 hlt=0",
                     bus_if.t_state, bus_if.con, bus_if.hlt);
        end
        checks++;
    endtask

    task automatic test_lda();
        logic [5:0]  et [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        logic [11:0] ec [7] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};
        bus_if.opcode  = 4'h0;
        bus_if.step_en = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {et[i], ec[i], 1'b0}) begin
                errors++;
                $display("FAIL lda_cycle[%0d]: got t=%h con=%h hlt=%b, want t=%h con=%h hlt=0",
                         i, bus_if.t_state, bus_if.con, bus_if.hlt, et[i], ec[i]);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_add_sub();
        logic [3:0]  ops [2] = '{4'h2, 4'h1};
        logic [11:0] ec  [2][3] = '{'{12'h1A3, 12'h2E1, 12'h3CF}, '{12'h1A3, 12'h2E1, 12'h3C7}};
        bus_if.step_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus_if.opcode = ops[k];
            do_reset();
            tick(); tick(); tick();
            for (int i = 0; i < 3; i++) begin
                if ({bus_if.t_state, bus_if.con} !== {6'(6'h08 << i), ec[k][i]}) begin
                    errors++;
                    $display("FAIL alu_op%h_T%0d: got t=%h con=%h, want t=%h con=%h",
                             ops[k], i + 4, bus_if.t_state, bus_if.con, 6'(6'h08 << i), ec[k][i]);
                end
                checks++;
                tick();
            end
        end
    endtask

    task automatic test_halt();
        bus_if.step_en = 1'b1;
        bus_if.opcode  = 4'hF;
        do_reset();
        tick(); tick(); tick();
        for (int i = 0; i < 21; i++) begin
            if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {6'h08, 12'h3E3, 1'b1}) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got t=%h con=%h hlt=%b, want t=08 con=3E3 hlt=1",
                         i, bus_if.t_state, bus_if.con, bus_if.hlt);
            end
            checks++;
            tick();
        end
        bus_if.opcode = 4'h0;
        #1;
        if (bus_if.hlt !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky: got hlt=%b, want hlt=1", bus_if.hlt);
        end
        checks++;
        do_reset();
        if ({bus_if.t_state, bus_if.hlt} !== {6'h01, 1'b0}) begin
            errors++;
            $display("FAIL halt_clear: got t=%h hlt=%b, want t=01 hlt=0", bus_if.t_state, bus_if.hlt);
        end
        checks++;
    endtask

    task automatic test_step_hold();
        bus_if.step_en = 1'b1;
        bus_if.opcode  = 4'h0;
        do_reset();
        tick(); tick();
        bus_if.step_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({bus_if.t_state, bus_if.con} !== {6'h04, 12'h263}) begin
                errors++;
                $display("FAIL step_hold[%0d]: got t=%h con=%h, want t=04 con=263",
                         i, bus_if.t_state, bus_if.con);
            end
            checks++;
        end
        bus_if.step_en = 1'b1;
        tick();
        if ({bus_if.t_state, bus_if.con} !== {6'h08, 12'h1A3}) begin
            errors++;
            $display("FAIL step_resume: got t=%h con=%h, want t=08 con=1A3", bus_if.t_state, bus_if.con);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        bus_if.step_en = 1'b1;
        bus_if.opcode  = 4'h1;
        do_reset();
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {6'h10, 12'h3E3, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_T5: got t=%h con=%h hlt=%b, want t=10 con=3E3 hlt=0",
                     bus_if.t_state, bus_if.con, bus_if.hlt);
        end
        checks++;
        tick();
        reset = 1'b0;
        #1;
        if ({bus_if.t_state, bus_if.con} !== {6'h01, 12'h5E3}) begin
            errors++;
            $display("FAIL reset_mid_after: got t=%h con=%h, want t=01 con=5E3", bus_if.t_state, bus_if.con);
        end
        checks++;
    endtask

    task automatic test_undefined();
        bus_if.step_en = 1'b1;
        bus_if.opcode  = 4'h7;
        do_reset();
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {6'(6'h08 << i), 12'h3E3, 1'b0}) begin
                errors++;
                $display("FAIL nop_T%0d: got t=%h con=%h hlt=%b, want t=%h con=3E3 hlt=0",
                         i + 4, bus_if.t_state, bus_if.con, bus_if.hlt, 6'(6'h08 << i));
            end
            checks++;
            tick();
        end
        if ({bus_if.t_state, bus_if.con} !== {6'h01, 12'h5E3}) begin
            errors++;
            $display("FAIL nop_wrap: got t=%h con=%h, want t=01 con=5E3", bus_if.t_state, bus_if.con);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [5:0]  et;
        logic [11:0] ec;
        logic        eh;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 39) == 0);
            bus_if.step_en = ($urandom_range(0, 3) != 0);
            if (m_step <= 3) bus_if.opcode = 4'($urandom_range(0, 15));
            #1;
            et = 6'(1 << (m_step - 1));
            ec = exp_con(m_step, bus_if.opcode, m_halted, reset);
            eh = !reset && (m_halted || (m_step == 4 && bus_if.opcode == 4'hF));
            if ({bus_if.t_state, bus_if.con, bus_if.hlt} !== {et, ec, eh}) begin
                errors++;
                $display("FAIL random[%0d] op=%h rst=%b: got t=%h con=%h hlt=%b, want t=%h con=%h hlt=%b",
                         i, bus_if.opcode, reset, bus_if.t_state, bus_if.con, bus_if.hlt, et, ec, eh);
            end
            checks++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.step_en = 1'b0;
        bus_if.opcode  = 4'h0;
        test_reset();
        test_lda();
        test_add_sub();
        test_halt();
        test_step_hold();
        test_reset_mid();
        test_undefined();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
